// File: rtl/pad_reader_pkg.sv
// Shared definitions for the controller pad reader: FSM states, the
// button bit map and a small bit-insert helper.
package pad_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_CLK_LOW  = 3'd2,
    ST_CLK_HIGH = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int unsigned NUM_BTNS = 8;

  // Bit position of each button in buttons1/buttons2; also the serial
  // order in which the controller shifts them out.
  localparam logic [2:0] BTN_A      = 3'd0;
  localparam logic [2:0] BTN_B      = 3'd1;
  localparam logic [2:0] BTN_SELECT = 3'd2;
  localparam logic [2:0] BTN_START  = 3'd3;
  localparam logic [2:0] BTN_UP     = 3'd4;
  localparam logic [2:0] BTN_DOWN   = 3'd5;
  localparam logic [2:0] BTN_LEFT   = 3'd6;
  localparam logic [2:0] BTN_RIGHT  = 3'd7;

  // Return v with bit idx replaced by b.
  function automatic logic [NUM_BTNS-1:0] set_bit(input logic [NUM_BTNS-1:0] v,
                                                  input logic [2:0]          idx,
                                                  input logic                b);
    logic [NUM_BTNS-1:0] r;
    r      = v;
    r[idx] = b;
    return r;
  endfunction

endpackage

// File: rtl/pad_reader_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit. Reset value is
// a parameter so idle-high lines come out of reset at their idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is safe to use downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pad_reader.sv
// Reads two serial game controllers sharing one latch/clock pair. A
// free-running poll counter starts a frame on each wrap; the frame
// latches the pads, clocks out 8 buttons and publishes both bytes at once.
module pad_reader
  import pad_reader_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 648,
  parameter int unsigned POLL_CYCLES = 1800000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pad1_data,
  input  logic       pad2_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons1,
  output logic [7:0] buttons2,
  output logic       valid
);

  localparam int unsigned POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned PH_W   = $clog2(2 * HALF_CYCLES);

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * HALF_CYCLES - 1);
  localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_CYCLES - 1);

  // A frame must finish before the next poll wrap.
  generate
    if (POLL_CYCLES <= 16 * HALF_CYCLES + 4) begin : g_bad_cfg
      $error("pad_reader: POLL_CYCLES must exceed 16*HALF_CYCLES+4");
    end
  endgenerate

  // Synchronized pad lines (idle high = no button pressed).
  logic pad1_s;
  logic pad2_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_pad1 (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (pad1_data),
    .q_o   (pad1_s)
  );

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_pad2 (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (pad2_data),
    .q_o   (pad2_s)
  );

  // Poll counter.
  logic [POLL_W-1:0] poll_q;
  logic [POLL_W-1:0] poll_d;
  logic              tick;

  assign tick = (poll_q == POLL_LAST);

  // Next poll count: wrap to zero on the tick cycle.
  always_comb begin
    poll_d = poll_q + POLL_W'(1);
    if (tick) poll_d = '0;
  end

  // Free-running poll counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) poll_q <= '0;
    else       poll_q <= poll_d;
  end

  // Frame state.
  state_e          state_q;
  logic [PH_W-1:0] phase_q;
  logic [2:0]      bit_q;
  logic [7:0]      sr1_q;
  logic [7:0]      sr2_q;
  logic [7:0]      btn1_q;
  logic [7:0]      btn2_q;
  logic            latch_q;
  logic            pclk_q;
  logic            valid_q;

  // Shift registers with the current bit inserted (buttons active-high).
  logic [7:0] sr1_d;
  logic [7:0] sr2_d;

  // Insert the freshly sampled bit at its own position so a completed
  // frame lands directly in button-map order.
  always_comb begin
    sr1_d = set_bit(sr1_q, bit_q, ~pad1_s);
    sr2_d = set_bit(sr2_q, bit_q, ~pad2_s);
  end

  // Frame sequencer with registered pad strobes and outputs. Shift
  // registers stay internal until DONE so partial frames never leak.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= BTN_A;
      sr1_q   <= '0;
      sr2_q   <= '0;
      btn1_q  <= '0;
      btn2_q  <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          latch_q <= 1'b0;
          pclk_q  <= 1'b1;
          if (tick && enable) begin
            state_q <= ST_LATCH;
            phase_q <= '0;
            bit_q   <= BTN_A;
            latch_q <= 1'b1;
          end
        end

        ST_LATCH: begin
          if (phase_q == LATCH_LAST) begin
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            bit_q   <= BTN_B;
            latch_q <= 1'b0;
            pclk_q  <= 1'b0;
            phase_q <= '0;
            state_q <= ST_CLK_LOW;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

        ST_CLK_LOW: begin
          if (phase_q == HALF_LAST) begin
            pclk_q  <= 1'b1;
            phase_q <= '0;
            state_q <= ST_CLK_HIGH;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

        ST_CLK_HIGH: begin
          if (phase_q == HALF_LAST) begin
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            phase_q <= '0;
            if (bit_q == BTN_RIGHT) begin
              // Last bit: publish both pads together.
              btn1_q  <= sr1_d;
              btn2_q  <= sr2_d;
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              bit_q   <= bit_q + 3'd1;
              pclk_q  <= 1'b0;
              state_q <= ST_CLK_LOW;
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

        ST_DONE: begin
          phase_q <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          latch_q <= 1'b0;
          pclk_q  <= 1'b1;
          phase_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;
  assign buttons1  = btn1_q;
  assign buttons2  = btn2_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_pad_reader.sv
// Bench for pad_reader: two behavioural controllers (parallel-load shift
// registers), a scoreboard of expected bytes snapshotted at latch, and a
// monitor that checks frame timing and output stability.
module tb_pad_reader;
  import pad_reader_pkg::*;

  localparam int HALF = 4;
  localparam int POLL = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pad1_data, pad2_data;
  logic       pad_latch, pad_clk, valid;
  logic [7:0] buttons1, buttons2;

  always #5 clock = ~clock;

  pad_reader #(.HALF_CYCLES(HALF), .POLL_CYCLES(POLL)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .pad1_data (pad1_data),
    .pad2_data (pad2_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons1  (buttons1),
    .buttons2  (buttons2),
    .valid     (valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller models: pressed = active-high button state held by the pad.
  logic [7:0] pressed1 = 8'h00, pressed2 = 8'h00;
  logic [7:0] sh1 = 8'h00, sh2 = 8'h00;

  assign pad1_data = ~sh1[0];
  assign pad2_data = ~sh2[0];

  // Latch loads the pad register; each pad_clk rise presents the next button.
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) begin
      sh1 <= pressed1;
      sh2 <= pressed2;
    end else begin
      sh1 <= {1'b0, sh1[7:1]};
      sh2 <= {1'b0, sh2[7:1]};
    end
  end

  // Scoreboard: a frame reports what the pads held when latched.
  logic [15:0] exp_q[$];
  always @(posedge pad_latch) exp_q.push_back({pressed1, pressed2});

  // Monitor state.
  int   cyc = 0, rise_cyc = 0, last_rise = -1;
  int   latch_len = 0, low_len = 0, pulses = 0, bad_w = 0;
  int   latch_rises = 0, valid_cnt = 0;
  logic lat_prev = 1'b0, clk_prev = 1'b1, val_prev = 1'b0;
  logic [15:0] btn_prev = 16'h0;
  logic [15:0] exp_v;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      last_rise = -1;
      latch_len = 0; pulses = 0; low_len = 0; bad_w = 0;
      lat_prev = 1'b0; clk_prev = 1'b1; val_prev = 1'b0;
      btn_prev = {buttons1, buttons2};
    end else begin
      if (pad_latch && !lat_prev) begin
        if (last_rise >= 0) chk("latch_period", (cyc - last_rise) % POLL, 0);
        last_rise = cyc; rise_cyc = cyc;
        latch_len = 0; pulses = 0; bad_w = 0; low_len = 0;
        latch_rises++;
      end
      if (pad_latch) latch_len++;
      if (!pad_clk) low_len++;
      else if (!clk_prev) begin
        pulses++;
        if (low_len != HALF) bad_w++;
        low_len = 0;
      end
      if (valid) begin
        valid_cnt++;
        chk("valid_one_cycle", val_prev, 0);
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          chk("sb_buttons1", buttons1, exp_v[15:8]);
          chk("sb_buttons2", buttons2, exp_v[7:0]);
        end
        chk("latch_len", latch_len, 2 * HALF);
        chk("clk_pulses", pulses, 7);
        chk("clk_low_width_errs", bad_w, 0);
        chk("valid_latency", cyc - rise_cyc, 16 * HALF);
      end else begin
        chk("hold_between_frames", {buttons1, buttons2}, btn_prev);
      end
      btn_prev = {buttons1, buttons2};
      lat_prev = pad_latch; clk_prev = pad_clk; val_prev = valid;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Wait for a valid pulse; optionally scramble the pads while waiting.
  task automatic wait_valid(input bit rnd);
    for (int i = 0; i < 300; i++) begin
      step();
      if (valid) break;
      if (rnd && !pad_latch && $urandom_range(0, 15) == 0) begin
        pressed1 = 8'($urandom);
        pressed2 = 8'($urandom);
      end
    end
    chk("wait_valid", valid, 1);
  endtask

  // Wait until the current frame has produced n pad_clk rises.
  task automatic wait_pulses(input int n);
    for (int i = 0; i < 300 && !pad_latch; i++) step();
    for (int i = 0; i < 300 && pulses != n; i++) step();
    chk("wait_pulses", pulses, n);
  endtask

  int base_l, base_v, k;

  initial begin
    reset = 1'b1; enable = 1'b0;
    repeat (3) step();
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 1);
    chk("rst_b1", buttons1, 8'h00);
    chk("rst_b2", buttons2, 8'h00);
    chk("rst_valid", valid, 0);
    reset = 1'b0;

    // Disabled: no frames at all.
    base_l = latch_rises; base_v = valid_cnt;
    repeat (500) step();
    chk("dis_latch_rises", latch_rises - base_l, 0);
    chk("dis_valids", valid_cnt - base_v, 0);

    // A + Start on pad1, pad2 idle.
    pressed1 = 8'((1 << BTN_A) | (1 << BTN_START));
    pressed2 = 8'h00;
    enable = 1'b1;
    wait_valid(0);
    chk("a_start_b1", buttons1, 8'h09);
    chk("a_start_b2", buttons2, 8'h00);

    // Right only on pad1, everything on pad2.
    pressed1 = 8'(1 << BTN_RIGHT);
    pressed2 = 8'hFF;
    wait_valid(0);
    chk("right_b1", buttons1, 8'h80);
    chk("all_b2", buttons2, 8'hFF);

    // Random pad activity, including changes while a frame is shifting.
    repeat (25) wait_valid(1);

    // Enable dropped at bit 3: the frame completes, nothing after.
    pressed1 = 8'h3C; pressed2 = 8'hC3;
    wait_pulses(3);
    enable = 1'b0;
    wait_valid(0);
    chk("drop_b1", buttons1, 8'h3C);
    base_l = latch_rises; base_v = valid_cnt;
    repeat (400) step();
    chk("drop_no_latch", latch_rises - base_l, 0);
    chk("drop_no_valid", valid_cnt - base_v, 0);

    // Reset at bit 5 with outputs showing 0x55.
    pressed1 = 8'h55; pressed2 = 8'hAA;
    enable = 1'b1;
    wait_valid(0);
    chk("pre_rst_b1", buttons1, 8'h55);
    pressed1 = 8'h0F; pressed2 = 8'hF0;
    wait_pulses(5);
    reset = 1'b1;
    #1;
    chk("mid_rst_b1", buttons1, 8'h00);
    chk("mid_rst_b2", buttons2, 8'h00);
    chk("mid_rst_clk", pad_clk, 1);
    chk("mid_rst_latch", pad_latch, 0);
    chk("mid_rst_valid", valid, 0);
    repeat (2) step();
    @(negedge clock);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      k++;
      if (valid) break;
    end
    chk("first_valid_after_rst", k, POLL + 16 * HALF);
    chk("post_rst_b1", buttons1, 8'h0F);
    chk("post_rst_b2", buttons2, 8'hF0);

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_reader.md
PAD_READER -- requirements
Module: pad_reader

Interface
REQ-001 Parameter HALF_CYCLES, default 648, clock cycles per half bit period (6 us at 108 MHz).
REQ-002 Parameter POLL_CYCLES, default 1800000, clock cycles between frame starts (60 Hz at 108 MHz); SHALL exceed 16*HALF_CYCLES+4, checked at elaboration.
REQ-003 clock  input  1  system clock (108 MHz PLL output); single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high permits new frames to start.
REQ-006 pad1_data  input  1  serial data from controller 1, active-low button level, asynchronous.
REQ-007 pad2_data  input  1  serial data from controller 2, active-low, asynchronous.
REQ-008 pad_latch  output  1  latch strobe shared by both controllers, active-high.
REQ-009 pad_clk  output  1  shift clock shared by both controllers, idles high.
REQ-010 buttons1  output  8  controller 1 state, active-high: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-011 buttons2  output  8  controller 2 state, same bit map.
REQ-012 valid  output  1  one-cycle pulse when buttons1/buttons2 update.

Function
REQ-013 pad1_data and pad2_data SHALL pass through a 2-flop synchronizer before any use; all sampling uses synchronized values.
REQ-014 A free-running poll counter SHALL count 0..POLL_CYCLES-1 and wrap; a frame-start tick occurs on the wrap cycle.
REQ-015 States: IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE.
REQ-016 IDLE: pad_latch=0, pad_clk=1; on frame-start tick with enable=1 go to LATCH; tick with enable=0 is ignored.
REQ-017 LATCH: pad_latch=1 for 2*HALF_CYCLES cycles; on its last cycle sample bit0 of both pads (inverted) into shift registers, go to CLK_LOW.
REQ-018 CLK_LOW: pad_clk=0 for HALF_CYCLES cycles, then CLK_HIGH.
REQ-019 CLK_HIGH: pad_clk=1 for HALF_CYCLES cycles; on its last cycle sample next bit (bits 1..7 in order); after bit7 go to DONE, else CLK_LOW.
REQ-020 Exactly 7 pad_clk low pulses per frame; frame length 16*HALF_CYCLES cycles from LATCH entry to DONE entry.
REQ-021 DONE (one cycle): buttons1/buttons2 load complete shift registers simultaneously, valid=1, then IDLE.
REQ-022 Outputs SHALL hold between frames; partial data never reaches buttons1/buttons2.
REQ-023 enable deasserting mid-frame SHALL NOT abort the frame; it completes and updates outputs.
REQ-024 Bit counter 3 bits; phase counter wide enough for 2*HALF_CYCLES-1, reset to 0 on each state entry.
REQ-025 Disconnected pad (data pulled high) SHALL read 8'h00.

Reset
REQ-026 While reset=1: state IDLE, pad_latch=0, pad_clk=1, buttons1=buttons2=8'h00, valid=0, all counters and synchronizers 0 (synchronizers to 1, idle data level).
REQ-027 Reset asserted mid-frame SHALL abort immediately; after release the first frame starts on the next poll wrap, no valid before it completes.

Structure
REQ-028 Shared package holds the state enumeration and button bit-index constants (BTN_A..BTN_RIGHT) used also by statemachine.
REQ-029 One sub-module sync_2ff (1-bit, async reset to parameterized value), instanced once per pad data line.

Verification (HALF_CYCLES=4, POLL_CYCLES=100)
REQ-030 Pad1 model asserts A and Start (low on bits 0,3), pad2 idle high -> after DONE buttons1=8'h09, buttons2=8'h00, valid one cycle.
REQ-031 Frame timing: pad_latch high exactly 8 cycles, then exactly 7 pad_clk low pulses of 4 cycles each, valid 64 cycles after latch rise; next latch rise 100 cycles after previous.
REQ-032 Pad2 all buttons pressed, pad1 Right only -> buttons2=8'hFF, buttons1=8'h80.
REQ-033 enable=0 from reset -> no pad_latch activity, no valid over 500 cycles; enable dropped at bit 3 -> frame completes, valid once, no further frames.
REQ-034 reset asserted at bit 5 of a frame with buttons at 8'h55 -> outputs 8'h00, pad_clk=1, pad_latch=0 same cycle; no valid until next full frame.
REQ-035 Pad data changed mid-frame between frames -> outputs reflect only completed frames, never mixed bits visible outside DONE.
